// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised single-clock FIFO with an occupancy count,
// same-cycle status flags, programmable almost-full/almost-empty thresholds,
// read-while-full pass-through and a one-cycle read-data valid strobe.
// Optional sticky overflow/underflow flags are compiled in when the macro
// SYNC_FIFO_ERR_FLAGS_EN is defined; the default build omits them entirely.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  dout_valid_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  almost_full_s;
  logic                  almost_empty_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Status flags decoded straight from the registered count so they track it with no lag.
  always_comb begin
    full_s         = 1'b0;
    empty_s        = 1'b0;
    almost_full_s  = 1'b0;
    almost_empty_s = 1'b0;
    if (count_r == DEPTH_C) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (count_r == {(ADDR_WIDTH+1){1'b0}}) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    if (count_r >= AF_C) begin
      almost_full_s = 1'b1;
    end else begin
      almost_full_s = 1'b0;
    end
    if (count_r <= AE_C) begin
      almost_empty_s = 1'b1;
    end else begin
      almost_empty_s = 1'b0;
    end
  end

  // Accept decisions: a read frees the slot when full, so a paired write still lands.
  always_comb begin
    rd_acc_s = rd_en && !empty_s;
    wr_acc_s = wr_en && (!full_s || rd_en);
  end

  // Storage array; contents are deliberately left unreset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
      count_r      <= {(ADDR_WIDTH+1){1'b0}};
      dout_r       <= {DATA_WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r     <= rd_ptr_r + ADDR_WIDTH'(1);
        dout_r       <= mem_r[rd_ptr_r];
        dout_valid_r <= 1'b1;
      end else begin
        dout_valid_r <= 1'b0;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + (ADDR_WIDTH+1)'(1);
        2'b01:   count_r <= count_r - (ADDR_WIDTH+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a set event in the same cycle as err_clr takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en && !wr_acc_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end
      if (rd_en && empty_s) begin
        underflow_r <= 1'b1;
      end else if (err_clr) begin
        underflow_r <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

  assign dout         = dout_r;
  assign dout_valid   = dout_valid_r;
  assign count        = count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = almost_full_s;
  assign almost_empty = almost_empty_s;

endmodule
